ddram_arb: RTL and testbench

- Two-client round-robin arbiter that shares the single DE10-nano DDR3 Avalon-MM port (DDRAM_*) between two requesters, e.g. a core memory bridge and a video/save-state engine.
- Each client sees a full DDRAM-style port with its own busy and read-ready.
- The arbiter holds a grant across an entire write burst, or until all read beats are returned.
- It sits between the client bridges and the sys-level DDRAM_* pins.

---
 rtl/ddram_arb_pkg.sv | 31 +++
 rtl/ddram_arb_if.sv | 24 ++
 rtl/ddram_arb_rr.sv | 21 ++
 rtl/ddram_arb.sv | 128 ++++++++++++
 tb/tb_ddram_arb.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddram_arb_pkg.sv
// Shared types and widths for the two-client DDRAM arbiter.
package ddram_arb_pkg;

    localparam int unsigned AW  = 29;
    localparam int unsigned DW  = 64;
    localparam int unsigned BW  = 8;
    localparam int unsigned BEW = DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        WBURST,
        RWAIT
    } state_t;

    // One client's command bundle as presented to the shared port
    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [BW-1:0]  burstcnt;
        logic [DW-1:0]  din;
        logic [BEW-1:0] be;
        logic           rd;
        logic           we;
    } cmd_t;

    // A burst count of zero moves a single beat
    function automatic logic [BW-1:0] eff_burst(input logic [BW-1:0] bc);
        return (bc == '0) ? BW'(1) : bc;
    endfunction

endpackage

// File: rtl/ddram_arb_if.sv
// DDRAM-style Avalon-MM port; master issues commands, slave answers with busy/read data.
interface ddram_arb_if;

    logic                              busy;
    logic [ddram_arb_pkg::BW-1:0]      burstcnt;
    logic [ddram_arb_pkg::AW-1:0]      addr;
    logic                              rd;
    logic                              we;
    logic [ddram_arb_pkg::DW-1:0]      din;
    logic [ddram_arb_pkg::BEW-1:0]     be;
    logic [ddram_arb_pkg::DW-1:0]      dout;
    logic                              dout_ready;

    modport master (
        output burstcnt, addr, rd, we, din, be,
        input  busy, dout, dout_ready
    );

    modport slave (
        input  burstcnt, addr, rd, we, din, be,
        output busy, dout, dout_ready
    );

endinterface

// File: rtl/ddram_arb_rr.sv
// Two-way round-robin picker: the client that did not win last time wins a tie.
module ddram_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_c,
    output logic       valid_c
);

    // Winner selection; grant_c is only meaningful while valid_c is high
    always_comb begin
        valid_c = |req;
        grant_c = 1'b0;
        unique case (req)
            2'b01:   grant_c = 1'b0;
            2'b10:   grant_c = 1'b1;
            2'b11:   grant_c = ~last;
            default: grant_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/ddram_arb.sv
// Shares one DDR3 Avalon-MM port between two clients, holding the grant for a
// whole write burst or until every read beat has come back.
module ddram_arb
    import ddram_arb_pkg::*;
(
    input  logic         DDRAM_CLK,
    input  logic         RESET_N,
    ddram_arb_if.slave   c0,
    ddram_arb_if.slave   c1,
    ddram_arb_if.master  ddram
);

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q,  last_d;
    logic [BW-1:0]  beats_q, beats_d;

    cmd_t           c0_cmd, c1_cmd, own_cmd;
    logic [1:0]     req;
    logic           win;
    logic           win_valid;
    logic           own_req;

    // Read wins over write when a client raises both
    assign c0_cmd = '{addr: c0.addr, burstcnt: c0.burstcnt, din: c0.din, be: c0.be,
                      rd: c0.rd, we: c0.we & ~c0.rd};
    assign c1_cmd = '{addr: c1.addr, burstcnt: c1.burstcnt, din: c1.din, be: c1.be,
                      rd: c1.rd, we: c1.we & ~c1.rd};
    assign own_cmd = owner_q ? c1_cmd : c0_cmd;
    assign own_req = own_cmd.rd | own_cmd.we;
    assign req     = {c1_cmd.rd | c1_cmd.we, c0_cmd.rd | c0_cmd.we};

    // Read data is broadcast; only the ready strobe is steered
    assign c0.dout = ddram.dout;
    assign c1.dout = ddram.dout;

    ddram_arb_rr u_rr (
        .req     (req),
        .last    (last_q),
        .grant_c (win),
        .valid_c (win_valid)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge DDRAM_CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    // Next-state, command mux and per-client busy/ready steering
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_d           = last_q;
        beats_d          = beats_q;
        ddram.addr       = own_cmd.addr;
        ddram.burstcnt   = own_cmd.burstcnt;
        ddram.din        = own_cmd.din;
        ddram.be         = own_cmd.be;
        ddram.rd         = 1'b0;
        ddram.we         = 1'b0;
        c0.busy          = 1'b1;
        c1.busy          = 1'b1;
        c0.dout_ready    = 1'b0;
        c1.dout_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = win;
                    last_d  = win;
                    state_d = OWN;
                end
            end

            OWN: begin
                ddram.rd = own_cmd.rd;
                ddram.we = own_cmd.we;
                if (owner_q) c1.busy = ddram.busy;
                else         c0.busy = ddram.busy;
                if (!own_req) begin
                    state_d = IDLE;
                end else if (!ddram.busy) begin
                    if (own_cmd.rd) begin
                        beats_d = eff_burst(own_cmd.burstcnt);
                        state_d = RWAIT;
                    end else if (eff_burst(own_cmd.burstcnt) == BW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        beats_d = eff_burst(own_cmd.burstcnt) - BW'(1);
                        state_d = WBURST;
                    end
                end
            end

            WBURST: begin
                ddram.we = own_cmd.we;
                if (owner_q) c1.busy = ddram.busy;
                else         c0.busy = ddram.busy;
                if (own_cmd.we && !ddram.busy) begin
                    beats_d = beats_q - BW'(1);
                    if (beats_q <= BW'(1)) state_d = IDLE;
                end
            end

            RWAIT: begin
                if (owner_q) c1.dout_ready = ddram.dout_ready;
                else         c0.dout_ready = ddram.dout_ready;
                if (ddram.dout_ready) begin
                    beats_d = beats_q - BW'(1);
                    if (beats_q <= BW'(1)) state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddram_arb.sv
// Scoreboard bench for ddram_arb: stimulus queues expected DDR commands and
// read returns, a negedge monitor pops and compares as the DUT presents them.
module tb_ddram_arb;
    import ddram_arb_pkg::*;

    logic DDRAM_CLK = 1'b0;
    logic RESET_N   = 1'b0;

    ddram_arb_if c0_if ();
    ddram_arb_if c1_if ();
    ddram_arb_if dd_if ();

    ddram_arb dut (
        .DDRAM_CLK (DDRAM_CLK),
        .RESET_N   (RESET_N),
        .c0        (c0_if),
        .c1        (c1_if),
        .ddram     (dd_if)
    );

    always #5 DDRAM_CLK = ~DDRAM_CLK;

    typedef struct {
        logic          who;
        logic [DW-1:0] data;
    } ret_t;

    cmd_t exp_cmd[$];
    ret_t exp_ret[$];
    int   checks = 0;
    int   errors = 0;
    int   outstanding = 0;
    int   since_ret = 1000;
    cmd_t mon_e;
    ret_t mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic cmd_t mk(input logic [AW-1:0] a, input logic [BW-1:0] bc,
                                input logic [DW-1:0] d, input logic [BEW-1:0] b,
                                input logic r, input logic w);
        cmd_t c;
        c.addr = a; c.burstcnt = bc; c.din = d; c.be = b; c.rd = r; c.we = w;
        return c;
    endfunction

    // Monitor: every accepted DDR command and every routed read beat is checked
    always @(negedge DDRAM_CLK) begin
        if (!RESET_N) begin
            outstanding = 0;
        end else begin
            since_ret++;
            if ((dd_if.rd || dd_if.we) && !dd_if.busy) begin
                check("no_grant_while_reading", 64'(outstanding), 64'(0));
                check("idle_gap", 64'(since_ret >= 2), 64'(1));
                if (exp_cmd.size() == 0) begin
                    check("unexpected_cmd", 64'(dd_if.addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = exp_cmd.pop_front();
                    check("cmd_addr", 64'(dd_if.addr), 64'(mon_e.addr));
                    check("cmd_burstcnt", 64'(dd_if.burstcnt), 64'(mon_e.burstcnt));
                    check("cmd_rd", 64'(dd_if.rd), 64'(mon_e.rd));
                    check("cmd_we", 64'(dd_if.we), 64'(mon_e.we));
                    if (mon_e.we) begin
                        check("cmd_din", dd_if.din, mon_e.din);
                        check("cmd_be", 64'(dd_if.be), 64'(mon_e.be));
                    end
                end
                if (dd_if.rd) outstanding = int'(eff_burst(dd_if.burstcnt));
            end
            if (c0_if.dout_ready || c1_if.dout_ready) begin
                since_ret = 0;
                if (exp_ret.size() == 0) begin
                    check("unexpected_ret", {62'd0, c1_if.dout_ready, c0_if.dout_ready}, 64'd0);
                end else begin
                    mon_r = exp_ret.pop_front();
                    check("ret_c0_ready", 64'(c0_if.dout_ready), 64'(!mon_r.who));
                    check("ret_c1_ready", 64'(c1_if.dout_ready), 64'(mon_r.who));
                    check("ret_data", mon_r.who ? c1_if.dout : c0_if.dout, mon_r.data);
                end
                if (outstanding > 0) outstanding--;
            end
        end
    end

    task automatic tick();
        @(posedge DDRAM_CLK);
        #1;
    endtask

    task automatic set_client(input logic who, input cmd_t c);
        if (who) begin
            c1_if.addr = c.addr; c1_if.burstcnt = c.burstcnt; c1_if.din = c.din;
            c1_if.be = c.be; c1_if.rd = c.rd; c1_if.we = c.we;
        end else begin
            c0_if.addr = c.addr; c0_if.burstcnt = c.burstcnt; c0_if.din = c.din;
            c0_if.be = c.be; c0_if.rd = c.rd; c0_if.we = c.we;
        end
    endtask

    task automatic drop_client(input logic who);
        if (who) begin c1_if.rd = 1'b0; c1_if.we = 1'b0; end
        else     begin c0_if.rd = 1'b0; c0_if.we = 1'b0; end
    endtask

    // Wait (bounded) for the cycle in which the given client's command is taken
    task automatic wait_accept(input logic who, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge DDRAM_CLK);
            if ((who ? c1_if.busy : c0_if.busy) == 1'b0) begin
                got = 1'b1;
                check({name, "_other_busy"}, 64'(who ? c0_if.busy : c1_if.busy), 64'(1));
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_accept required=accept", name);
        end
        @(posedge DDRAM_CLK);
        #1;
    endtask

    task automatic wait_dd_accept(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge DDRAM_CLK);
            if ((dd_if.rd || dd_if.we) && !dd_if.busy) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_accept required=accept", name);
        end
        @(posedge DDRAM_CLK);
        #1;
    endtask

    task automatic send_ret(input logic who, input logic [DW-1:0] data, input int gap);
        ret_t r;
        repeat (gap) tick();
        r.who = who;
        r.data = data;
        exp_ret.push_back(r);
        dd_if.dout = data;
        dd_if.dout_ready = 1'b1;
        @(negedge DDRAM_CLK);
        check("dout_broadcast", who ? c0_if.dout : c1_if.dout, data);
        @(posedge DDRAM_CLK);
        #1;
        dd_if.dout_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_client(1'b0, mk('0, '0, '0, '0, 1'b0, 1'b0));
        set_client(1'b1, mk('0, '0, '0, '0, 1'b0, 1'b0));
        dd_if.busy = 1'b0;
        dd_if.dout = '0;
        dd_if.dout_ready = 1'b1;
        c0_if.rd = 1'b1;
        RESET_N = 1'b0;
        repeat (3) tick();

        // Reset state
        @(negedge DDRAM_CLK);
        check("rst_c0_busy", 64'(c0_if.busy), 64'(1));
        check("rst_c1_busy", 64'(c1_if.busy), 64'(1));
        check("rst_dd_rd", 64'(dd_if.rd), 64'(0));
        check("rst_dd_we", 64'(dd_if.we), 64'(0));
        check("rst_c0_ready", 64'(c0_if.dout_ready), 64'(0));
        check("rst_state", 64'(dut.state_q), 64'(IDLE));
        tick();
        c0_if.rd = 1'b0;
        dd_if.dout_ready = 1'b0;
        RESET_N = 1'b1;
        tick();

        // Single write from C0
        exp_cmd.push_back(mk(29'h0000100, 8'd1, 64'h1111_2222_3333_4444, 8'h5A, 1'b0, 1'b1));
        set_client(1'b0, mk(29'h0000100, 8'd1, 64'h1111_2222_3333_4444, 8'h5A, 1'b0, 1'b1));
        wait_accept(1'b0, "t1_write");
        drop_client(1'b0);
        check("t1_state_idle", 64'(dut.state_q), 64'(IDLE));

        // Read burst of 4 from C1; a C0 write waits behind it
        exp_cmd.push_back(mk(29'h0ABCDE0, 8'd4, '0, '0, 1'b1, 1'b0));
        set_client(1'b1, mk(29'h0ABCDE0, 8'd4, '0, '0, 1'b1, 1'b0));
        wait_accept(1'b1, "t2_read");
        drop_client(1'b1);
        check("t2_state_rwait", 64'(dut.state_q), 64'(RWAIT));
        exp_cmd.push_back(mk(29'h0000200, 8'd1, 64'hAAAA_0000_BBBB_0001, 8'hFF, 1'b0, 1'b1));
        set_client(1'b0, mk(29'h0000200, 8'd1, 64'hAAAA_0000_BBBB_0001, 8'hFF, 1'b0, 1'b1));
        for (int k = 0; k < 4; k++) send_ret(1'b1, 64'hD000_0000_0000_0000 + 64'(k), 2);
        wait_accept(1'b0, "t2_c0_write");
        drop_client(1'b0);

        // Contention on single-beat reads after reset: C0, C1, C0, C1
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        for (int k = 0; k < 4; k++)
            exp_cmd.push_back(mk((k % 2) ? 29'h0000400 : 29'h0000300, 8'd1, '0, '0, 1'b1, 1'b0));
        set_client(1'b0, mk(29'h0000300, 8'd1, '0, '0, 1'b1, 1'b0));
        set_client(1'b1, mk(29'h0000400, 8'd1, '0, '0, 1'b1, 1'b0));
        for (int k = 0; k < 4; k++) begin
            wait_dd_accept("t3_read");
            if (k == 3) begin
                drop_client(1'b0);
                drop_client(1'b1);
            end
            send_ret(1'(k % 2), 64'hC0C1_0000_0000_0000 + 64'(k), 0);
        end
        tick();

        // Write burst of 3 from C0 with the controller stalling beat 2
        exp_cmd.push_back(mk(29'h0000500, 8'd3, 64'h0000_0000_0000_00B0, 8'hFF, 1'b0, 1'b1));
        exp_cmd.push_back(mk(29'h0000500, 8'd3, 64'h0000_0000_0000_00B1, 8'hFF, 1'b0, 1'b1));
        exp_cmd.push_back(mk(29'h0000500, 8'd3, 64'h0000_0000_0000_00B2, 8'hFF, 1'b0, 1'b1));
        set_client(1'b0, mk(29'h0000500, 8'd3, 64'h0000_0000_0000_00B0, 8'hFF, 1'b0, 1'b1));
        wait_accept(1'b0, "t4_beat0");
        c0_if.din = 64'h0000_0000_0000_00B1;
        dd_if.busy = 1'b1;
        repeat (3) begin
            @(negedge DDRAM_CLK);
            check("t4_busy_mirror", 64'(c0_if.busy), 64'(1));
            check("t4_state_wburst", 64'(dut.state_q), 64'(WBURST));
            @(posedge DDRAM_CLK);
            #1;
        end
        dd_if.busy = 1'b0;
        wait_accept(1'b0, "t4_beat1");
        c0_if.din = 64'h0000_0000_0000_00B2;
        check("t4_hold_after_beat2", 64'(dut.state_q), 64'(WBURST));
        wait_accept(1'b0, "t4_beat2");
        drop_client(1'b0);
        check("t4_release", 64'(dut.state_q), 64'(IDLE));

        // Reset during a read with 2 beats outstanding, then stray returns
        exp_cmd.push_back(mk(29'h0000600, 8'd4, '0, '0, 1'b1, 1'b0));
        set_client(1'b0, mk(29'h0000600, 8'd4, '0, '0, 1'b1, 1'b0));
        wait_accept(1'b0, "t5_read");
        drop_client(1'b0);
        send_ret(1'b0, 64'h5555_0000_0000_0000, 1);
        send_ret(1'b0, 64'h5555_0000_0000_0001, 1);
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        check("t5_state_idle", 64'(dut.state_q), 64'(IDLE));
        for (int k = 0; k < 2; k++) begin
            dd_if.dout = 64'hDEAD_0000_0000_0000 + 64'(k);
            dd_if.dout_ready = 1'b1;
            @(negedge DDRAM_CLK);
            check("t5_stray_c0", 64'(c0_if.dout_ready), 64'(0));
            check("t5_stray_c1", 64'(c1_if.dout_ready), 64'(0));
            @(posedge DDRAM_CLK);
            #1;
            dd_if.dout_ready = 1'b0;
            tick();
        end
        exp_cmd.push_back(mk(29'h0000700, 8'd1, 64'h7070_7070_7070_7070, 8'h0F, 1'b0, 1'b1));
        exp_cmd.push_back(mk(29'h0000780, 8'd1, 64'h7878_7878_7878_7878, 8'hF0, 1'b0, 1'b1));
        set_client(1'b0, mk(29'h0000700, 8'd1, 64'h7070_7070_7070_7070, 8'h0F, 1'b0, 1'b1));
        set_client(1'b1, mk(29'h0000780, 8'd1, 64'h7878_7878_7878_7878, 8'hF0, 1'b0, 1'b1));
        wait_accept(1'b0, "t5_c0_first");
        drop_client(1'b0);
        wait_accept(1'b1, "t5_c1_second");
        drop_client(1'b1);

        // Burst count 0 write is one beat; RD+WE together issues only RD
        exp_cmd.push_back(mk(29'h0000800, 8'd0, 64'h0808_0808_0808_0808, 8'h3C, 1'b0, 1'b1));
        set_client(1'b1, mk(29'h0000800, 8'd0, 64'h0808_0808_0808_0808, 8'h3C, 1'b0, 1'b1));
        wait_accept(1'b1, "t6_bc0_write");
        drop_client(1'b1);
        check("t6_bc0_single", 64'(dut.state_q), 64'(IDLE));
        exp_cmd.push_back(mk(29'h0000900, 8'd1, '0, '0, 1'b1, 1'b0));
        set_client(1'b0, mk(29'h0000900, 8'd1, 64'h0909_0909_0909_0909, 8'hFF, 1'b1, 1'b1));
        wait_accept(1'b0, "t6_rdwe");
        drop_client(1'b0);
        check("t6_state_rwait", 64'(dut.state_q), 64'(RWAIT));
        send_ret(1'b0, 64'h9999_0000_0000_0009, 1);
        check("t6_state_idle", 64'(dut.state_q), 64'(IDLE));

        repeat (4) tick();
        check("cmd_queue_drained", 64'(exp_cmd.size()), 64'(0));
        check("ret_queue_drained", 64'(exp_ret.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
